// File: rtl/mult_pipe.sv
// Pipelined shift-add multiplier with valid/ready flow control.
// Each stage retires NUM_BITS multiplier bits; bubbles collapse under stall.
module mult_pipe #(
    parameter int XLEN       = 8,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_signed,
    input  logic [XLEN-1:0]                 mplier_in,
    input  logic [XLEN-1:0]                 mcand_in,
    input  logic [TAG_W-1:0]                tag_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*XLEN-1:0]               product_out,
    output logic [TAG_W-1:0]                tag_out,
    output logic [$clog2(NUM_STAGES+1)-1:0] occupancy
);

    localparam int PW       = 2 * XLEN;
    localparam int NUM_BITS = PW / NUM_STAGES;
    localparam int OCC_W    = $clog2(NUM_STAGES + 1);

    if (NUM_STAGES < 1 || NUM_STAGES > PW || (PW % NUM_STAGES) != 0) begin : g_bad_cfg
        $error("mult_pipe: NUM_STAGES must divide 2*XLEN");
    end

    typedef struct packed {
        logic [PW-1:0]    prod;
        logic [PW-1:0]    mplier;
        logic [PW-1:0]    mcand;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic stage_t step(input stage_t s);
        stage_t        r;
        logic [PW-1:0] acc;
        acc = s.prod;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (s.mplier[i]) begin
                acc = acc + (s.mcand << i);
            end
        end
        r        = s;
        r.prod   = acc;
        r.mplier = s.mplier >> NUM_BITS;
        r.mcand  = s.mcand << NUM_BITS;
        return r;
    endfunction

    stage_t                  stg_q [NUM_STAGES];
    stage_t                  load_s;
    logic [NUM_STAGES-1:0]   vld_q;
    logic [NUM_STAGES-1:0]   vld_d;
    logic [NUM_STAGES-1:0]   adv;
    logic                    accept;

    // Extension happens once at acceptance, so in_signed need not travel.
    always_comb begin
        load_s        = '0;
        load_s.mplier = {{XLEN{in_signed & mplier_in[XLEN-1]}}, mplier_in};
        load_s.mcand  = {{XLEN{in_signed & mcand_in[XLEN-1]}}, mcand_in};
        load_s.tag    = tag_in;
    end

    // A stage moves if any stage above it is empty or the sink takes data.
    always_comb begin : adv_chain
        logic room;
        room = out_ready;
        adv  = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & room;
            room   = room | ~vld_q[k];
        end
    end

    assign in_ready = ~vld_q[0] | adv[0];
    assign accept   = in_valid & in_ready;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept | (vld_q[0] & ~adv[0]);
        for (int k = 1; k < NUM_STAGES; k++) begin
            vld_d[k] = adv[k-1] | (vld_q[k] & ~adv[k]);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occupancy = occupancy + OCC_W'(vld_q[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q                    <= '0;
            stg_q[NUM_STAGES-1].prod <= '0;
            stg_q[NUM_STAGES-1].tag  <= '0;
        end else begin
            vld_q <= flush ? '0 : vld_d;
            if (accept) begin
                stg_q[0] <= step(load_s);
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (adv[k-1]) begin
                    stg_q[k] <= step(stg_q[k-1]);
                end
            end
        end
    end

    assign out_valid   = vld_q[NUM_STAGES-1];
    assign product_out = stg_q[NUM_STAGES-1].prod;
    assign tag_out     = stg_q[NUM_STAGES-1].tag;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: default, 1-stage and 16-stage instances
// share stimulus; each has its own in-order result scoreboard.
module tb_mult_pipe;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_signed, out_ready;
    logic [7:0]  mplier_in, mcand_in;
    logic [3:0]  tag_in;

    logic        in_ready, out_valid;
    logic [15:0] product_out;
    logic [3:0]  tag_out;
    logic [2:0]  occupancy;

    logic        n1_rdy, n1_vld;
    logic [15:0] n1_prod;
    logic [3:0]  n1_tag;
    logic [0:0]  n1_occ;

    logic        n16_rdy, n16_vld;
    logic [15:0] n16_prod;
    logic [3:0]  n16_tag;
    logic [4:0]  n16_occ;

    int vectors     = 0;
    int miscompares = 0;
    int n1_seen     = 0;
    int n16_seen    = 0;
    int vidx        = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] q16[$];

    mult_pipe u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .mplier_in(mplier_in), .mcand_in(mcand_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .product_out(product_out), .tag_out(tag_out), .occupancy(occupancy)
    );

    mult_pipe #(.NUM_STAGES(1)) u_n1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n1_rdy), .in_signed(in_signed),
        .mplier_in(mplier_in), .mcand_in(mcand_in), .tag_in(tag_in),
        .out_valid(n1_vld), .out_ready(1'b1),
        .product_out(n1_prod), .tag_out(n1_tag), .occupancy(n1_occ)
    );

    mult_pipe #(.NUM_STAGES(16)) u_n16 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n16_rdy), .in_signed(in_signed),
        .mplier_in(mplier_in), .mcand_in(mcand_in), .tag_in(tag_in),
        .out_valid(n16_vld), .out_ready(1'b1),
        .product_out(n16_prod), .tag_out(n16_tag), .occupancy(n16_occ)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    function automatic logic [19:0] vec_exp(input int i);
        return {4'(i), ref_mul((i % 3) == 0, 8'(i * 53 + 7), 8'(i * 91 + 200))};
    endfunction

    task automatic set_vec(input int i);
        in_signed = (i % 3) == 0;
        mplier_in = 8'(i * 53 + 7);
        mcand_in  = 8'(i * 91 + 200);
        tag_in    = 4'(i);
    endtask

    // Scoreboards: check presented results, then record the upcoming edge.
    always @(negedge clock) begin
        logic [19:0] e;
        if (out_valid === 1'b1 && out_ready) begin
            if (q0.size() == 0) check("dut_spurious", 32'(out_valid), 32'd0);
            else begin
                e = q0.pop_front();
                check("dut_result", 32'({tag_out, product_out}), 32'(e));
            end
        end
        if (n1_vld === 1'b1) begin
            n1_seen++;
            if (q1.size() == 0) check("n1_spurious", 32'(n1_vld), 32'd0);
            else begin
                e = q1.pop_front();
                check("n1_result", 32'({n1_tag, n1_prod}), 32'(e));
            end
        end
        if (n16_vld === 1'b1) begin
            n16_seen++;
            if (q16.size() == 0) check("n16_spurious", 32'(n16_vld), 32'd0);
            else begin
                e = q16.pop_front();
                check("n16_result", 32'({n16_tag, n16_prod}), 32'(e));
            end
        end
        if (reset || flush) begin
            q0.delete();
            q1.delete();
            q16.delete();
        end else if (in_valid) begin
            e = {tag_in, ref_mul(in_signed, mplier_in, mcand_in)};
            if (in_ready) q0.push_back(e);
            if (n1_rdy) q1.push_back(e);
            if (n16_rdy) q16.push_back(e);
        end
    end

    task automatic send_wait(input logic s, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] t, input logic [15:0] exp, input string nm);
        int n;
        in_valid  = 1'b1;
        in_signed = s;
        mplier_in = a;
        mcand_in  = b;
        tag_in    = t;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (out_valid !== 1'b1 && n < 20);
        check({nm, "_lat"}, n, 4);
        check(nm, 32'(product_out), 32'(exp));
        check({nm, "_tag"}, 32'(tag_out), 32'(t));
        @(posedge clock); #1;
    endtask

    task automatic stall_fill(input int bub, output int acc);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c != bub);
            set_vec(vidx);
            @(negedge clock);
            if (in_valid && in_ready) begin
                acc++;
                vidx++;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        out_ready = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid === 1'b1) n++;
        end
        check({nm, "_cnt"}, n, 4);
        check({nm, "_occ"}, 32'(occupancy), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, h;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_vec(0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_prod", 32'(product_out), 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        send_wait(1'b0, 8'hFF, 8'hFF, 4'h5, 16'hFE01, "u_ff_ff");
        send_wait(1'b1, 8'h80, 8'h7F, 4'h6, 16'hC080, "s_80_7f");
        send_wait(1'b1, 8'hFF, 8'hFF, 4'h7, 16'h0001, "s_ff_ff");
        send_wait(1'b0, 8'hFF, 8'h02, 4'h8, 16'h01FE, "u_ff_02");

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            set_vec(vidx);
            vidx++;
            @(posedge clock); #1;
            if (i >= 3) check("b2b_valid", 32'(out_valid), 32'd1);
            if (i == 5) check("b2b_occ", 32'(occupancy), 32'd4);
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            check("b2b_tail", 32'(out_valid), 32'd1);
        end
        @(posedge clock); #1;
        check("b2b_empty", 32'(out_valid), 32'd0);
        check("b2b_occ0", 32'(occupancy), 32'd0);

        out_ready = 1'b0;
        h = vidx;
        stall_fill(-1, acc);
        check("stall_acc", acc, 4);
        check("stall_rdy", 32'(in_ready), 32'd0);
        check("stall_occ", 32'(occupancy), 32'd4);
        repeat (3) begin
            @(negedge clock);
            check("stall_hold", 32'({tag_out, product_out}), 32'(vec_exp(h)));
        end
        @(posedge clock); #1;
        drain("stall_drain");

        out_ready = 1'b0;
        stall_fill(1, acc);
        check("bubble_acc", acc, 4);
        check("bubble_rdy", 32'(in_ready), 32'd0);
        drain("bubble_drain");

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_vec(vidx);
            vidx++;
            @(posedge clock); #1;
        end
        check("flush_pre_occ", 32'(occupancy), 32'd3);
        flush = 1'b1;
        set_vec(vidx);
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_vec(vidx);
            vidx++;
            @(posedge clock); #1;
        end
        check("reset_pre_occ", 32'(occupancy), 32'd3);
        reset = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_prod", 32'(product_out), 32'd0);
        check("reset_tag", 32'(tag_out), 32'd0);
        check("n1_occ_rst", 32'(n1_occ), 32'd0);
        check("n16_occ_rst", 32'(n16_occ), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("reset_no_stale", 32'(out_valid), 32'd0);

        send_wait(1'b1, 8'h80, 8'h80, 4'h9, 16'h4000, "s_80_80");
        send_wait(1'b0, 8'h0F, 8'h10, 4'hA, 16'h00F0, "u_0f_10");
        repeat (20) @(posedge clock);
        #1;
        check("n1_results", 32'(n1_seen > 20), 32'd1);
        check("n16_results", 32'(n16_seen > 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
